// File: rtl/axi_lite_regfile_slave_pkg.sv
// Shared AXI4-Lite types: response codes and read/write FSM state encodings.
// Pure declarations; no latency and no flow control of its own.
package axi_lite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/axi_lite_regfile_slave_if.sv
// AXI4-Lite five-channel bundle with master/slave views.
// Wires only; valid/ready handshake semantics are owned by the endpoints.
interface axi_lite_regfile_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import axi_lite_pkg::*;

    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    resp_t               bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    resp_t               rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_regfile_slave_mem.sv
// DEPTH x DATA_W register array, cleared on reset, byte-enable write port.
// Read data registered one edge after rd_en_i and held until the next read.
module axi_lite_regfile_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                aclk,
    input  logic                areset_n,
    input  logic                wr_en_i,
    input  logic [IDX_W-1:0]    wr_idx_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    input  logic                rd_en_i,
    input  logic                rd_ok_i,
    input  logic [IDX_W-1:0]    rd_idx_i,
    output logic [DATA_W-1:0]   rd_data_o
);
    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Read and write share one edge: the read samples the pre-write contents.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (rd_en_i) begin
                rd_data_q <= rd_ok_i ? mem_q[rd_idx_i] : '0;
            end
            if (wr_en_i) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_be_i[b]) begin
                        mem_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite register-file slave; read data 1 cycle after AR, B 1 cycle after AW+W held.
// Valids held until ready; byte strobes honoured only with AXIL_REGFILE_WSTRB_EN.
module axi_lite_regfile_slave
    import axi_lite_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    axi_lite_regfile_slave_if.slave   s_axi
);
    localparam int                STRB_W = DATA_W / 8;
    localparam int                LSB    = $clog2(STRB_W);
    localparam int                IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(DEPTH * STRB_W);

    rd_state_e rd_state_q, rd_state_d;
    wr_state_e wr_state_q, wr_state_d;

    logic              ar_rdy, ar_hs, r_vld;
    logic              aw_rdy, aw_hs, w_rdy, w_hs, b_vld, commit;
    logic              aw_held_q, w_held_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wr_be;
    resp_t             rresp_q, bresp_q;

    // Subtraction wraps addresses below BASE_ADDR to large offsets, so one compare covers both ends.
    logic [ADDR_W-1:0] ar_off, aw_off;
    logic              ar_ok, aw_ok;
    logic [IDX_W-1:0]  ar_idx, aw_idx;

    assign ar_off = s_axi.araddr - BASE_ADDR;
    assign aw_off = awaddr_q - BASE_ADDR;
    assign ar_ok  = ar_off < SPAN;
    assign aw_ok  = aw_off < SPAN;
    assign ar_idx = IDX_W'(ar_off >> LSB);
    assign aw_idx = IDX_W'(aw_off >> LSB);

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            rd_state_q <= R_IDLE;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        ar_rdy     = 1'b0;
        ar_hs      = 1'b0;
        r_vld      = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                ar_rdy = areset_n;
                if (ar_rdy && s_axi.arvalid) begin
                    ar_hs      = 1'b1;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                r_vld = 1'b1;
                if (s_axi.rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rresp_q <= ar_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            wr_state_q <= W_COLLECT;
        end else begin
            wr_state_q <= wr_state_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_rdy     = 1'b0;
        w_rdy      = 1'b0;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        b_vld      = 1'b0;
        commit     = 1'b0;
        case (wr_state_q)
            W_COLLECT: begin
                aw_rdy = areset_n && !aw_held_q;
                w_rdy  = areset_n && !w_held_q;
                aw_hs  = aw_rdy && s_axi.awvalid;
                w_hs   = w_rdy && s_axi.wvalid;
                if (aw_held_q && w_held_q) begin
                    commit     = 1'b1;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (s_axi.bready) begin
                    wr_state_d = W_COLLECT;
                end
            end
            default: wr_state_d = W_COLLECT;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bresp_q   <= aw_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= s_axi.awaddr;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                wdata_q  <= s_axi.wdata;
            end
        end
    end

`ifdef AXIL_REGFILE_WSTRB_EN
    logic [STRB_W-1:0] wstrb_q;

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            wstrb_q <= '0;
        end else if (w_hs) begin
            wstrb_q <= s_axi.wstrb;
        end
    end

    assign wr_be = wstrb_q;
`else
    assign wr_be = '1;
`endif

    axi_lite_regfile_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .wr_en_i   (commit && aw_ok),
        .wr_idx_i  (aw_idx),
        .wr_data_i (wdata_q),
        .wr_be_i   (wr_be),
        .rd_en_i   (ar_hs),
        .rd_ok_i   (ar_ok),
        .rd_idx_i  (ar_idx),
        .rd_data_o (s_axi.rdata)
    );

    assign s_axi.arready = ar_rdy;
    assign s_axi.rvalid  = r_vld;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.awready = aw_rdy;
    assign s_axi.wready  = w_rdy;
    assign s_axi.bvalid  = b_vld;
    assign s_axi.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Bench for axi_lite_regfile_slave: directed scenarios plus random AXI-Lite traffic,
// every cycle compared against a transaction-level model of the register file.
module tb_axi_lite_regfile_slave;

    localparam int DEPTH = 32;
`ifdef AXIL_REGFILE_WSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic aclk = 1'b0;
    logic areset_n;

    always #5 aclk = ~aclk;

    axi_lite_regfile_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_regfile_slave #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .DEPTH     (DEPTH),
        .BASE_ADDR (32'h0)
    ) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .s_axi    (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a word array plus "what is outstanding" per channel.
    logic [31:0] m_mem [DEPTH];
    bit          m_r_pend, m_b_pend, m_aw_have, m_w_have;
    logic [31:0] m_rdata, m_awaddr, m_wdata;
    logic [1:0]  m_rresp, m_bresp;
    logic [3:0]  m_wstrb;

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (!STRB_EN || strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    always @(posedge aclk) begin
        if (!areset_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
            m_r_pend  <= 1'b0;
            m_b_pend  <= 1'b0;
            m_aw_have <= 1'b0;
            m_w_have  <= 1'b0;
        end else begin
            if (m_r_pend) begin
                if (bus.rready) m_r_pend <= 1'b0;
            end else if (bus.arvalid) begin
                m_r_pend <= 1'b1;
                m_rdata  <= in_range(bus.araddr) ? m_mem[bus.araddr[6:2]] : 32'h0;
                m_rresp  <= in_range(bus.araddr) ? 2'b00 : 2'b10;
            end
            if (m_b_pend) begin
                if (bus.bready) m_b_pend <= 1'b0;
            end else if (m_aw_have && m_w_have) begin
                if (in_range(m_awaddr)) begin
                    m_mem[m_awaddr[6:2]] <= merge(m_mem[m_awaddr[6:2]], m_wdata, m_wstrb);
                end
                m_bresp   <= in_range(m_awaddr) ? 2'b00 : 2'b10;
                m_b_pend  <= 1'b1;
                m_aw_have <= 1'b0;
                m_w_have  <= 1'b0;
            end else begin
                if (bus.awvalid && !m_aw_have) begin
                    m_aw_have <= 1'b1;
                    m_awaddr  <= bus.awaddr;
                end
                if (bus.wvalid && !m_w_have) begin
                    m_w_have <= 1'b1;
                    m_wdata  <= bus.wdata;
                    m_wstrb  <= bus.wstrb;
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (cmp_en) begin
            chk("rvalid", 32'(bus.rvalid), 32'(m_r_pend));
            if (m_r_pend) begin
                chk("rdata", bus.rdata, m_rdata);
                chk("rresp", 32'(bus.rresp), 32'(m_rresp));
            end
            chk("bvalid", 32'(bus.bvalid), 32'(m_b_pend));
            if (m_b_pend) chk("bresp", 32'(bus.bresp), 32'(m_bresp));
            chk("arready", 32'(bus.arready), 32'(areset_n && !m_r_pend));
            chk("awready", 32'(bus.awready), 32'(areset_n && !m_b_pend && !m_aw_have));
            chk("wready", 32'(bus.wready), 32'(areset_n && !m_b_pend && !m_w_have));
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp);
        bit seen;
        int n;
        @(posedge aclk);
        fork
            begin
                bit hs;
                int k;
                repeat (aw_dly) @(posedge aclk);
                #1;
                bus.awaddr  = addr;
                bus.awvalid = 1'b1;
                hs = 1'b0;
                k  = 0;
                while (!hs && k < 64) begin
                    @(negedge aclk);
                    hs = bus.awready;
                    @(posedge aclk);
                    #1;
                    k++;
                end
                bus.awvalid = 1'b0;
                chk("aw_handshake", 32'(hs), 32'd1);
            end
            begin
                bit hs;
                int k;
                repeat (w_dly) @(posedge aclk);
                #1;
                bus.wdata  = data;
                bus.wstrb  = strb;
                bus.wvalid = 1'b1;
                hs = 1'b0;
                k  = 0;
                while (!hs && k < 64) begin
                    @(negedge aclk);
                    hs = bus.wready;
                    @(posedge aclk);
                    #1;
                    k++;
                end
                bus.wvalid = 1'b0;
                chk("w_handshake", 32'(hs), 32'd1);
            end
        join
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 64) begin
            @(negedge aclk);
            seen = bus.bvalid;
            n++;
        end
        chk("b_arrives", 32'(seen), 32'd1);
        resp = bus.bresp;
        repeat (b_dly) @(negedge aclk);
        @(posedge aclk);
        #1 bus.bready = 1'b1;
        @(posedge aclk);
        #1 bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
        bit hs;
        bit seen;
        int k;
        @(posedge aclk);
        repeat (ar_dly) @(posedge aclk);
        #1;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        hs = 1'b0;
        k  = 0;
        while (!hs && k < 64) begin
            @(negedge aclk);
            hs = bus.arready;
            @(posedge aclk);
            #1;
            k++;
        end
        bus.arvalid = 1'b0;
        chk("ar_handshake", 32'(hs), 32'd1);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 64) begin
            @(negedge aclk);
            seen = bus.rvalid;
            lat++;
        end
        data = bus.rdata;
        resp = bus.rresp;
        repeat (r_dly) @(negedge aclk);
        @(posedge aclk);
        #1 bus.rready = 1'b1;
        @(posedge aclk);
        #1 bus.rready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [1:0]  wr;
        int          lat;
        logic [31:0] exp_t3;

        areset_n    = 1'b0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        repeat (2) @(posedge aclk);
        #1 cmp_en = 1'b1;
        @(negedge aclk);
        chk("reset_rdata", bus.rdata, 32'h0);
        chk("reset_rresp", 32'(bus.rresp), 32'd0);
        chk("reset_bresp", 32'(bus.bresp), 32'd0);
        chk("reset_awready", 32'(bus.awready), 32'd0);
        @(posedge aclk);
        #1 areset_n = 1'b1;

        // Read from a freshly reset word
        do_read(32'hC, 0, 0, d, r, lat);
        chk("t1_rdata", d, 32'h0);
        chk("t1_rresp", 32'(r), 32'd0);
        chk("t1_latency", 32'(lat), 32'd1);

        // W arrives two cycles before AW
        do_write(32'h8, 32'hDEADBEEF, 4'hF, 2, 0, 0, wr);
        chk("t2_bresp", 32'(wr), 32'd0);
        do_read(32'h8, 0, 0, d, r, lat);
        chk("t2_rdata", d, 32'hDEADBEEF);

        // Partial strobe write
        exp_t3 = STRB_EN ? 32'h11BB33DD : 32'hAABBCCDD;
        do_write(32'h10, 32'h11223344, 4'hF, 0, 0, 0, wr);
        do_write(32'h10, 32'hAABBCCDD, 4'b0101, 0, 1, 0, wr);
        chk("t3_bresp", 32'(wr), 32'd0);
        do_read(32'h10, 0, 0, d, r, lat);
        chk("t3_rdata", d, exp_t3);

        // One word past the end
        do_write(32'h80, 32'h5A5A5A5A, 4'hF, 0, 0, 0, wr);
        chk("t4_bresp", 32'(wr), 32'd2);
        do_read(32'h80, 0, 0, d, r, lat);
        chk("t4_rdata", d, 32'h0);
        chk("t4_rresp", 32'(r), 32'd2);
        do_read(32'h0, 0, 0, d, r, lat);
        chk("t4_word0_untouched", d, 32'h0);

        // AR lands on the commit edge of a write to the same word
        do_write(32'h14, 32'h01010101, 4'hF, 0, 0, 0, wr);
        fork
            do_write(32'h14, 32'h02020202, 4'hF, 0, 0, 0, wr);
            do_read(32'h14, 1, 0, d, r, lat);
        join
        chk("t5_old_value", d, 32'h01010101);
        do_read(32'h14, 0, 0, d, r, lat);
        chk("t5_new_value", d, 32'h02020202);

        // Slow B and R consumers
        do_write(32'h18, 32'hCAFEF00D, 4'hF, 1, 0, 5, wr);
        chk("t6_bresp", 32'(wr), 32'd0);
        do_read(32'h1B, 0, 5, d, r, lat);
        chk("t6_rdata", d, 32'hCAFEF00D);

        // Reset while AW and W are both held, before the commit edge
        do_write(32'h1C, 32'h12345678, 4'hF, 0, 0, 0, wr);
        @(posedge aclk);
        #1;
        bus.awaddr  = 32'h1C;
        bus.wdata   = 32'h00000055;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        @(posedge aclk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        areset_n    = 1'b0;
        @(posedge aclk);
        #1 areset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("t6_no_bvalid_after_reset", 32'(bus.bvalid), 32'd0);
        end
        do_read(32'h1C, 0, 0, d, r, lat);
        chk("t6_reset_word", d, 32'h0);

        // Random traffic; the per-cycle compare process does the checking
        for (int it = 0; it < 150; it++) begin
            logic [31:0] wa, ra, wd;
            logic [3:0]  ws;
            int          op;
            op = $urandom_range(0, 2);
            wa = ($urandom_range(0, 3) == 0) ? 32'h20 : 32'($urandom_range(0, DEPTH * 4 + 15));
            ra = ($urandom_range(0, 3) == 0) ? 32'h20 : 32'($urandom_range(0, DEPTH * 4 + 15));
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            case (op)
                0: do_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3), wr);
                1: do_read(ra, $urandom_range(0, 2), $urandom_range(0, 3), d, r, lat);
                default: begin
                    fork
                        do_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3),
                                 $urandom_range(0, 3), wr);
                        do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), d, r, lat);
                    join
                end
            endcase
        end

        repeat (3) @(posedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
